// File: rtl/xadc_multichannel_packetizer.sv
// XADC multichannel packetizer: round-robin merge of 16-bit sample streams
// into 2-byte packets {chan_id, result[11:8]}, {result[7:0]} on an 8-bit stream.
// Disabled channels are drained and counted in a saturating dropped-sample counter.
module xadc_multichannel_packetizer #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_LSB   = 4,
    parameter int TLAST_MODE   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CHANNELS-1:0]    channel_enable,
    input  logic [16*NUM_CHANNELS-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]    s_tvalid,
    output logic [NUM_CHANNELS-1:0]    s_tready,
    output logic [7:0]                 m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [15:0]                dropped_count
);

    localparam int   PTR_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic TLAST_ON_SWEEP = (TLAST_MODE == 1);

    typedef enum logic [1:0] {
        AWAIT,
        SEND_UPPER,
        SEND_LOWER
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] high_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             grant_found;
    logic             accept;
    logic             sweep_end;
    logic [11:0]      grant_sample;
    logic [7:0]       upper_byte;
    logic [7:0]       lower_hold;
    logic             eos_hold;
    logic [4:0]       drop_inc;
    logic [16:0]      drop_sum;
    logic             unused_sample_bits;

    // Sample bits outside the 12-bit result field are intentionally ignored
    assign unused_sample_bits = ^s_tdata;

    // Round-robin search: first enabled, valid channel at or above rr_ptr (wrapping)
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            sel = PTR_W'(idx);
            if (!grant_found && channel_enable[sel] && s_tvalid[sel]) begin
                grant_found = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    // Select the granted channel's 12-bit result field
    always_comb begin
        grant_sample = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                grant_sample = s_tdata[16*k+SAMPLE_LSB +: 12];
            end
        end
    end

    // Highest enabled channel marks the end of a sweep
    always_comb begin
        high_idx = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (channel_enable[k]) begin
                high_idx = PTR_W'(k);
            end
        end
    end

    // A new sample may be taken when idle or while the lower byte is being handed off
    always_comb begin
        accept     = !reset && grant_found &&
                     ((state == AWAIT) || ((state == SEND_LOWER) && m_tready));
        sweep_end  = (grant_idx == high_idx);
        next_ptr   = (grant_idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);
        upper_byte = {4'(grant_idx), grant_sample[11:8]};
    end

    // Disabled channels are always ready; enabled ones only on their own grant
    always_comb begin
        s_tready = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            s_tready[k] = !channel_enable[k] || (accept && (grant_idx == PTR_W'(k)));
        end
    end

    // Count samples handshaken on disabled channels this cycle
    always_comb begin
        drop_inc = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!channel_enable[k] && s_tvalid[k]) begin
                drop_inc = drop_inc + 5'd1;
            end
        end
        drop_sum = {1'b0, dropped_count} + {12'b0, drop_inc};
    end

    // Packet FSM: latch on accept, emit upper then lower byte with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= AWAIT;
            rr_ptr     <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= '0;
            lower_hold <= '0;
            eos_hold   <= 1'b0;
        end else if (accept) begin
            state      <= SEND_UPPER;
            m_tvalid   <= 1'b1;
            m_tdata    <= upper_byte;
            m_tlast    <= 1'b0;
            lower_hold <= grant_sample[7:0];
            eos_hold   <= sweep_end;
            rr_ptr     <= next_ptr;
        end else begin
            case (state)
                AWAIT: begin
                    m_tvalid <= 1'b0;
                end
                SEND_UPPER: begin
                    if (m_tready) begin
                        state   <= SEND_LOWER;
                        m_tdata <= lower_hold;
                        m_tlast <= TLAST_ON_SWEEP ? eos_hold : 1'b1;
                    end
                end
                SEND_LOWER: begin
                    if (m_tready) begin
                        state    <= AWAIT;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        m_tdata  <= '0;
                    end
                end
                default: begin
                    state    <= AWAIT;
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating dropped-sample counter
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_count <= '0;
        end else if (drop_sum[16]) begin
            dropped_count <= 16'hFFFF;
        end else begin
            dropped_count <= drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_xadc_multichannel_packetizer.sv
// Testbench for xadc_multichannel_packetizer: two instances (2 channels / TLAST on
// every packet, 4 channels / TLAST at end of sweep) against a byte-queue reference model.
module tb_xadc_multichannel_packetizer;

    localparam int LSB = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  en_a, vld_a, srdy_a;
    logic [31:0] data_a;
    logic        rdy_a, tvalid_a, tlast_a;
    logic [7:0]  tdata_a;
    logic [15:0] drop_a;

    logic [3:0]  en_b, vld_b, srdy_b;
    logic [63:0] data_b;
    logic        rdy_b, tvalid_b, tlast_b;
    logic [7:0]  tdata_b;
    logic [15:0] drop_b;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance: pending output bytes {tlast, data}
    logic [8:0] m_q [2][2];
    int         m_cnt [2];
    int         m_rr [2];
    int         m_drop [2];
    bit         m_after_reset [2];

    xadc_multichannel_packetizer #(.NUM_CHANNELS(2), .SAMPLE_LSB(LSB), .TLAST_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .channel_enable(en_a), .s_tdata(data_a), .s_tvalid(vld_a),
        .s_tready(srdy_a), .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(rdy_a),
        .m_tlast(tlast_a), .dropped_count(drop_a));

    xadc_multichannel_packetizer #(.NUM_CHANNELS(4), .SAMPLE_LSB(LSB), .TLAST_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .channel_enable(en_b), .s_tdata(data_b), .s_tvalid(vld_b),
        .s_tready(srdy_b), .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(rdy_b),
        .m_tlast(tlast_b), .dropped_count(drop_b));

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One cycle of the reference model: predicts ready lines, then advances byte queue
    task automatic modelStep(input int inst, input int n, input int mode, input logic [3:0] en,
                             input logic [3:0] vld, input logic [63:0] data, input logic rdy,
                             input logic rst, output logic [3:0] exp_sready);
        int         g, hi, nd, idx;
        bit         found, can_acc;
        logic [15:0] w;
        logic [11:0] sample;
        logic        last_bit;
        exp_sready = '0;
        for (int i = 0; i < n; i++) if (!en[i]) exp_sready[i] = 1'b1;
        if (rst) begin
            m_cnt[inst] = 0;
            m_rr[inst] = 0;
            m_drop[inst] = 0;
            m_after_reset[inst] = 1'b1;
        end else begin
            m_after_reset[inst] = 1'b0;
            nd = 0;
            for (int i = 0; i < n; i++) if (!en[i] && vld[i]) nd++;
            m_drop[inst] = (m_drop[inst] + nd > 65535) ? 65535 : m_drop[inst] + nd;
            can_acc = (m_cnt[inst] == 0) || (m_cnt[inst] == 1 && rdy);
            found = 1'b0;
            g = 0;
            for (int k = 0; k < n; k++) begin
                idx = (m_rr[inst] + k) % n;
                if (!found && en[idx] && vld[idx]) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            hi = -1;
            for (int i = 0; i < n; i++) if (en[i]) hi = i;
            if (m_cnt[inst] > 0 && rdy) begin
                m_q[inst][0] = m_q[inst][1];
                m_cnt[inst]--;
            end
            if (can_acc && found) begin
                exp_sready[g] = 1'b1;
                w = data[16*g +: 16];
                sample = 12'(w >> LSB);
                last_bit = (mode == 0) ? 1'b1 : (g == hi);
                m_q[inst][0] = {1'b0, 4'(g), sample[11:8]};
                m_q[inst][1] = {last_bit, sample[7:0]};
                m_cnt[inst] = 2;
                m_rr[inst] = (g + 1) % n;
            end
        end
    endtask

    task automatic checkRegs(input int inst, input string p, input logic [7:0] td, input logic tv,
                             input logic tl, input logic [15:0] dc);
        checkOutput({p, "_tvalid"}, 32'(tv), 32'(m_cnt[inst] > 0));
        if (m_cnt[inst] > 0) begin
            checkOutput({p, "_tdata"}, 32'(td), 32'(m_q[inst][0][7:0]));
            checkOutput({p, "_tlast"}, 32'(tl), 32'(m_q[inst][0][8]));
        end else if (m_after_reset[inst]) begin
            checkOutput({p, "_tdata_rst"}, 32'(td), 32'h0);
            checkOutput({p, "_tlast_rst"}, 32'(tl), 32'h0);
        end
        checkOutput({p, "_dropped"}, 32'(dc), 32'(m_drop[inst]));
    endtask

    // Check combinational ready, advance the model, clock, then check registered outputs
    task automatic stepCycle();
        logic [3:0] exp_a, exp_b;
        #1;
        modelStep(0, 2, 0, {2'b00, en_a}, {2'b00, vld_a}, {32'h0, data_a}, rdy_a, reset, exp_a);
        modelStep(1, 4, 1, en_b, vld_b, data_b, rdy_b, reset, exp_b);
        checkOutput("a_s_tready", 32'(srdy_a), 32'(exp_a[1:0]));
        checkOutput("b_s_tready", 32'(srdy_b), 32'(exp_b));
        @(posedge clk);
        #1;
        checkRegs(0, "a", tdata_a, tvalid_a, tlast_a, drop_a);
        checkRegs(1, "b", tdata_b, tvalid_b, tlast_b, drop_b);
    endtask

    task automatic applyStimulus();
        if ($urandom_range(15) == 0) en_a = 2'($urandom);
        if ($urandom_range(15) == 0) en_b = 4'($urandom);
        vld_a  = 2'($urandom);
        vld_b  = 4'($urandom);
        data_a = $urandom;
        data_b = {$urandom, $urandom};
        rdy_a  = ($urandom_range(3) != 0);
        rdy_b  = ($urandom_range(3) != 0);
        reset  = ($urandom_range(199) == 0);
    endtask

    initial begin
        logic [7:0] seq_a [4];
        logic       last_a [4];
        int         order_b [6];
        int         base;
        logic [7:0] exp_up;

        seq_a   = '{8'h0A, 8'hBC, 8'h11, 8'h23};
        last_a  = '{1'b0, 1'b1, 1'b0, 1'b1};
        order_b = '{0, 1, 3, 0, 1, 3};

        reset = 1'b1;
        en_a = '0; vld_a = '0; data_a = '0; rdy_a = 1'b1;
        en_b = '0; vld_b = '0; data_b = '0; rdy_b = 1'b1;
        stepCycle();
        stepCycle();

        // Two-channel, TLAST on every packet, back-to-back bytes
        reset  = 1'b0;
        en_a   = 2'b11;
        vld_a  = 2'b11;
        data_a = {16'h1230, 16'hABC0};
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("t1_tvalid", 32'(tvalid_a), 32'h1);
            checkOutput("t1_tdata", 32'(tdata_a), 32'(seq_a[i]));
            checkOutput("t1_tlast", 32'(tlast_a), 32'(last_a[i]));
        end
        vld_a = 2'b00;
        stepCycle();
        stepCycle();
        en_a = 2'b00;

        // Four-channel sweep with channel 2 disabled: order 0,1,3 and TLAST on channel 3
        en_b   = 4'b1011;
        vld_b  = 4'b1111;
        data_b = {$urandom, $urandom};
        base   = m_drop[1];
        for (int j = 1; j <= 12; j++) begin
            stepCycle();
            if (j % 2 == 1) checkOutput("t2_chan", 32'(tdata_b[7:4]), 32'(order_b[(j-1)/2]));
            else checkOutput("t2_tlast", 32'(tlast_b), 32'(order_b[(j-1)/2] == 3));
            checkOutput("t2_dropped", 32'(drop_b), 32'(base + j));
        end

        // Backpressure during the upper byte
        stepCycle();
        exp_up = {4'h0, data_b[15:12]};
        checkOutput("t3_upper", 32'(tdata_b), 32'(exp_up));
        rdy_b = 1'b0;
        for (int j = 0; j < 5; j++) begin
            stepCycle();
            checkOutput("t3_hold_valid", 32'(tvalid_b), 32'h1);
            checkOutput("t3_hold_data", 32'(tdata_b), 32'(exp_up));
            checkOutput("t3_no_ready", 32'(srdy_b & en_b), 32'h0);
        end
        rdy_b = 1'b1;
        stepCycle();
        checkOutput("t3_lower", 32'(tdata_b), 32'(data_b[11:4]));
        stepCycle();
        checkOutput("t3_resume_chan", 32'(tdata_b[7:4]), 32'h1);

        // Reset while the lower byte is on the bus
        stepCycle();
        checkOutput("t5_in_lower_tlast", 32'(tlast_b), 32'h0);
        reset = 1'b1;
        stepCycle();
        checkOutput("t5_rst_valid", 32'(tvalid_b), 32'h0);
        reset = 1'b0;
        en_b  = 4'b1111;
        vld_b = 4'b1010;
        stepCycle();
        checkOutput("t5_first_grant", 32'(tdata_b[7:4]), 32'h1);

        // Mask cleared mid-packet: packet completes with its TLAST, then idle
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        en_b  = 4'b1000;
        vld_b = 4'b1000;
        stepCycle();
        checkOutput("t6_upper_chan", 32'(tdata_b[7:4]), 32'h3);
        en_b = 4'b0000;
        stepCycle();
        checkOutput("t6_lower_tlast", 32'(tlast_b), 32'h1);
        for (int j = 0; j < 3; j++) begin
            stepCycle();
            checkOutput("t6_idle", 32'(tvalid_b), 32'h0);
        end

        // Saturation of the dropped-sample counter
        en_a = 2'b00; vld_a = 2'b11;
        en_b = 4'b0000; vld_b = 4'b1111;
        for (int j = 0; j < 16390; j++) stepCycle();
        checkOutput("t4_saturated", 32'(drop_b), 32'hFFFF);
        for (int j = 0; j < 4; j++) stepCycle();
        checkOutput("t4_stays", 32'(drop_b), 32'hFFFF);

        // Randomized traffic with occasional mask changes and resets
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        en_a = 2'($urandom);
        en_b = 4'($urandom);
        for (int j = 0; j < 3000; j++) begin
            applyStimulus();
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
